// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : phase_timer
// Brief    : multi-phase countdown timer with auto-sequencing, hold, forced
//            load and optional one-shot extension (PHASE_TIMER_EXTEND_EN)
// Revision : 1.0
// ============================================================================
module phase_timer #(
  parameter int pNUM_PHASES = 3,
  parameter int pCNT_WIDTH  = 5,
  parameter int pPH_WIDTH   = 2,
  parameter int pEXT_TIME   = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              hold,
  input  logic [pNUM_PHASES-1:0]            init,
  input  logic [pNUM_PHASES*pCNT_WIDTH-1:0] dur,
  input  logic                              ext_req,
  output logic [pPH_WIDTH-1:0]              phase,
  output logic [pCNT_WIDTH-1:0]             cnt_out,
  output logic                              last,
  output logic                              phase_done,
  output logic                              ext_used
);

  localparam logic [pPH_WIDTH-1:0]  c_LAST_PH = pPH_WIDTH'(pNUM_PHASES - 1);
  localparam logic [pPH_WIDTH-1:0]  c_PH_ONE  = pPH_WIDTH'(1);
  localparam logic [pCNT_WIDTH-1:0] c_CNT_ONE = pCNT_WIDTH'(1);

  logic [pPH_WIDTH-1:0]  r_phase;
  logic [pCNT_WIDTH-1:0] r_cnt;
  logic                  r_phase_done;

  logic                  w_init_hit;
  logic [pPH_WIDTH-1:0]  w_init_idx;
  logic [pCNT_WIDTH-1:0] w_init_dur;
  logic [pPH_WIDTH-1:0]  w_next_phase;
  logic [pCNT_WIDTH-1:0] w_next_dur;
  logic                  w_zero;
  logic                  w_ext_grant;
  logic [pCNT_WIDTH-1:0] w_ext_cnt;

  assign w_zero       = (r_cnt == '0);
  assign w_next_phase = (r_phase == c_LAST_PH) ? '0 : r_phase + c_PH_ONE;

  // Scan downwards so the lowest set init bit is the one that sticks.
  always_comb begin
    w_init_hit = 1'b0;
    w_init_idx = '0;
    w_init_dur = '0;
    for (int k = pNUM_PHASES - 1; k >= 0; k--) begin
      if (init[k]) begin
        w_init_hit = 1'b1;
        w_init_idx = pPH_WIDTH'(k);
        w_init_dur = dur[k*pCNT_WIDTH +: pCNT_WIDTH];
      end
    end
  end

  always_comb begin
    w_next_dur = '0;
    for (int k = 0; k < pNUM_PHASES; k++) begin
      if (w_next_phase == pPH_WIDTH'(k)) begin
        w_next_dur = dur[k*pCNT_WIDTH +: pCNT_WIDTH];
      end
    end
  end

`ifdef PHASE_TIMER_EXTEND_EN
  logic                  r_ext_used;
  logic [pCNT_WIDTH:0]   w_ext_sum;

  // Grant is evaluated below init and hold in the register priority chain.
  assign w_ext_grant = ext_req && !w_zero && !r_ext_used;
  assign w_ext_sum   = {1'b0, r_cnt} + (pCNT_WIDTH+1)'(pEXT_TIME);
  assign w_ext_cnt   = w_ext_sum[pCNT_WIDTH] ? '1 : w_ext_sum[pCNT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext_used <= 1'b0;
    end else if (w_init_hit) begin
      r_ext_used <= 1'b0;
    end else if (hold) begin
      r_ext_used <= r_ext_used;
    end else if (w_ext_grant) begin
      r_ext_used <= 1'b1;
    end else if (en && w_zero) begin
      r_ext_used <= 1'b0;
    end
  end

  assign ext_used = r_ext_used;
`else
  logic w_unused_ext;

  assign w_unused_ext = ext_req;
  assign w_ext_grant  = 1'b0;
  assign w_ext_cnt    = r_cnt;
  assign ext_used     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase      <= c_LAST_PH;
      r_cnt        <= '0;
      r_phase_done <= 1'b0;
    end else if (w_init_hit) begin
      r_phase      <= w_init_idx;
      r_cnt        <= w_init_dur;
      r_phase_done <= 1'b0;
    end else if (hold) begin
      r_phase_done <= 1'b0;
    end else if (w_ext_grant) begin
      r_cnt        <= w_ext_cnt;
      r_phase_done <= 1'b0;
    end else if (en && w_zero) begin
      r_phase      <= w_next_phase;
      r_cnt        <= w_next_dur;
      r_phase_done <= 1'b1;
    end else begin
      r_phase_done <= 1'b0;
      if (en) begin
        r_cnt <= r_cnt - c_CNT_ONE;
      end
    end
  end

  assign phase      = r_phase;
  assign cnt_out    = r_cnt;
  assign last       = w_zero;
  assign phase_done = r_phase_done;

endmodule
`default_nettype wire

// File: tb/tb_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_timer
// Brief    : vector-table bench for phase_timer; extension checks run when
//            PHASE_TIMER_EXTEND_EN is defined
// Revision : 1.0
// ============================================================================
module tb_phase_timer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        hold;
  logic [2:0]  init;
  logic [14:0] dur;
  logic        ext_req;
  logic [1:0]  phase;
  logic [4:0]  cnt_out;
  logic        last;
  logic        phase_done;
  logic        ext_used;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        rst;
    logic        en;
    logic        hold;
    logic        ext;
    logic [2:0]  init;
    logic [14:0] dur;
    logic [1:0]  ph;
    logic [4:0]  cnt;
    logic        done;
  } vec_t;

  vec_t q[$];

  phase_timer #(
    .pNUM_PHASES(3),
    .pCNT_WIDTH (5),
    .pPH_WIDTH  (2),
    .pEXT_TIME  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .hold      (hold),
    .init      (init),
    .dur       (dur),
    .ext_req   (ext_req),
    .phase     (phase),
    .cnt_out   (cnt_out),
    .last      (last),
    .phase_done(phase_done),
    .ext_used  (ext_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic h, input logic x,
                     input logic [2:0] in, input logic [14:0] d,
                     input logic [1:0] p, input logic [4:0] c, input logic dn);
    vec_t v;
    v.rst = r; v.en = e; v.hold = h; v.ext = x; v.init = in; v.dur = d;
    v.ph = p; v.cnt = c; v.done = dn;
    q.push_back(v);
  endtask

  task automatic drive(input logic r, input logic e, input logic h, input logic x,
                       input logic [2:0] in, input logic [14:0] d);
    @(negedge clk);
    rst = r; en = e; hold = h; ext_req = x; init = in; dur = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input int idx, input logic [1:0] p,
                           input logic [4:0] c, input logic dn, input logic eu);
    chk({nm, "_phase"}, idx, 32'(phase), 32'(p));
    chk({nm, "_cnt"}, idx, 32'(cnt_out), 32'(c));
    chk({nm, "_last"}, idx, 32'(last), 32'(c == 5'd0));
    chk({nm, "_done"}, idx, 32'(phase_done), 32'(dn));
    chk({nm, "_ext_used"}, idx, 32'(ext_used), 32'(eu));
  endtask

  localparam logic [14:0] D  = {5'd18, 5'd3, 5'd15};
  localparam logic [14:0] DM = {5'd9,  5'd3, 5'd15};
  localparam logic [14:0] DB = {5'd9,  5'd0, 5'd15};

  initial begin
    int  ticks;
    bit  seen;
    int  exp_len[4];

    n_cmp = 0; n_bad = 0;
    rst = 1'b1; en = 1'b0; hold = 1'b0; ext_req = 1'b0; init = 3'b000; dur = D;

    // ---------------- vector table ----------------
    add(1, 0, 0, 0, 3'b000, D, 2'd2, 5'd0, 0);
    add(0, 1, 0, 0, 3'b000, D, 2'd0, 5'd15, 1);
    for (int i = 0; i < 15; i++) add(0, 1, 0, 0, 3'b000, D, 2'd0, 5'(14 - i), 0);
    add(0, 1, 0, 0, 3'b000, D, 2'd1, 5'd3, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 3'b000, D, 2'd1, 5'(2 - i), 0);
    add(0, 1, 0, 0, 3'b000, D, 2'd2, 5'd18, 1);
    for (int i = 0; i < 18; i++) add(0, 1, 0, 0, 3'b000, D, 2'd2, 5'(17 - i), 0);
    add(0, 1, 0, 0, 3'b000, D, 2'd0, 5'd15, 1);
    add(0, 1, 0, 0, 3'b000, D, 2'd0, 5'd14, 0);
    add(0, 1, 0, 0, 3'b110, D, 2'd1, 5'd3, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 3'b000, D, 2'd1, 5'd3, 0);
    add(0, 1, 0, 0, 3'b000, D, 2'd1, 5'd2, 0);
    add(0, 0, 0, 0, 3'b111, D, 2'd0, 5'd15, 0);
    add(0, 1, 1, 0, 3'b100, D, 2'd2, 5'd18, 0);
    add(0, 0, 0, 0, 3'b000, D, 2'd2, 5'd18, 0);
    add(0, 1, 0, 0, 3'b000, DM, 2'd2, 5'd17, 0);
    add(0, 0, 0, 0, 3'b001, DB, 2'd0, 5'd15, 0);
    for (int i = 0; i < 15; i++) add(0, 1, 0, 0, 3'b000, DB, 2'd0, 5'(14 - i), 0);
    add(0, 1, 0, 0, 3'b000, DB, 2'd1, 5'd0, 1);
    add(0, 1, 0, 0, 3'b000, DB, 2'd2, 5'd9, 1);
    add(0, 1, 0, 0, 3'b000, DB, 2'd2, 5'd8, 0);
    add(0, 1, 0, 0, 3'b000, DB, 2'd2, 5'd7, 0);
    add(1, 1, 0, 0, 3'b000, DB, 2'd2, 5'd0, 0);
    add(0, 1, 0, 0, 3'b000, DB, 2'd0, 5'd15, 1);
`ifndef PHASE_TIMER_EXTEND_EN
    // Extension requests must be inert when the feature is not built.
    for (int i = 0; i < 15; i++) add(0, 1, 0, 1, 3'b000, DB, 2'd0, 5'(14 - i), 0);
    add(0, 1, 0, 1, 3'b000, DB, 2'd1, 5'd0, 1);
`endif

    for (int i = 0; i < q.size(); i++) begin
      drive(q[i].rst, q[i].en, q[i].hold, q[i].ext, q[i].init, q[i].dur);
      chk_state("vec", i, q[i].ph, q[i].cnt, q[i].done, 1'b0);
    end

    // ---------------- phase length between done pulses ----------------
    exp_len[0] = 1;  exp_len[1] = 16; exp_len[2] = 4; exp_len[3] = 19;
    drive(1, 0, 0, 0, 3'b000, D);
    for (int p = 0; p < 4; p++) begin
      ticks = 0;
      seen  = 0;
      while (!seen && ticks < 100) begin
        drive(0, 1, 0, 0, 3'b000, D);
        ticks++;
        if (phase_done) seen = 1;
      end
      chk("phase_len", p, 32'(ticks), 32'(exp_len[p]));
    end

`ifdef PHASE_TIMER_EXTEND_EN
    // ---------------- extension grant / one-shot / saturation ----------------
    drive(1, 0, 0, 0, 3'b000, D);
    chk_state("ext_rst", 0, 2'd2, 5'd0, 1'b0, 1'b0);
    drive(0, 1, 0, 0, 3'b000, D);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 3'b000, D);
    chk_state("ext_pre", 0, 2'd0, 5'd10, 1'b0, 1'b0);
    drive(0, 1, 0, 1, 3'b000, D);
    chk_state("ext_grant", 0, 2'd0, 5'd15, 1'b0, 1'b1);
    drive(0, 1, 0, 1, 3'b000, D);
    chk_state("ext_second", 0, 2'd0, 5'd14, 1'b0, 1'b1);
    drive(0, 0, 0, 0, 3'b010, {5'd18, 5'd29, 5'd15});
    chk_state("ext_load", 0, 2'd1, 5'd29, 1'b0, 1'b0);
    drive(0, 0, 1, 1, 3'b000, D);
    chk_state("ext_hold", 0, 2'd1, 5'd29, 1'b0, 1'b0);
    drive(0, 0, 0, 1, 3'b000, D);
    chk_state("ext_sat", 0, 2'd1, 5'd31, 1'b0, 1'b1);
    drive(0, 1, 0, 0, 3'b000, D);
    chk_state("ext_after", 0, 2'd1, 5'd30, 1'b0, 1'b1);
    drive(1, 0, 0, 0, 3'b000, D);
    chk_state("ext_clr", 0, 2'd2, 5'd0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phase_timer.md
# phase_timer

Parametrised multi-phase countdown timer for the traffic-light controller. It generalises the fixed green/yellow/red counter to `pNUM_PHASES` phases with run-time per-phase durations. It also adds automatic phase sequencing with wrap-around, a hold input and an optional one-shot time extension. It sits between the controller FSM and the light decoder: the FSM supplies a tick strobe and occasional forced loads, and the block owns phase timing.

## Interface
Parameters:
- `pNUM_PHASES`, default 3: number of phases, ≥2; phase k is slice k of `dur`.
- `pCNT_WIDTH`, default 5: counter width in bits.
- `pPH_WIDTH`, default 2: phase index width; must satisfy 2^pPH_WIDTH ≥ pNUM_PHASES.
- `pEXT_TIME`, default 5: ticks added by an extension; only used with `PHASE_TIMER_EXTEND_EN`.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `en`, input, 1: count tick strobe, one cycle per time unit.
- `hold`, input, 1: freezes counter and phase.
- `init`, input, pNUM_PHASES: one-hot forced phase load; lowest set index wins.
- `dur`, input, pNUM_PHASES*pCNT_WIDTH: per-phase durations; bits [k*W +: W] belong to phase k.
- `ext_req`, input, 1: extension request; ignored when the macro is absent.
- `phase`, output, pPH_WIDTH: current phase index.
- `cnt_out`, output, pCNT_WIDTH: current count.
- `last`, output, 1: combinational, high while `cnt_out` == 0.
- `phase_done`, output, 1: registered one-cycle pulse on automatic phase advance.
- `ext_used`, output, 1: extension already granted in the current phase; constant 0 when the macro is absent.

## Operation
- Reset values: `phase` = pNUM_PHASES-1, `cnt_out` = 0, `last` = 1, `phase_done` = 0, `ext_used` = 0. The first `en` tick after reset therefore advances to phase 0.
- Per-cycle priority, highest first:
  1. `rst`.
  2. `init`: `phase` ← k, `cnt_out` ← dur[k], `ext_used` ← 0, no `phase_done`.
  3. `hold`: all registers keep their value, `phase_done` ← 0.
  4. Extension grant (macro only).
  5. `en` with `cnt_out` == 0: advance. `phase` ← (phase == pNUM_PHASES-1) ? 0 : phase+1, `cnt_out` ← dur[next], `ext_used` ← 0, `phase_done` ← 1.
  6. `en` with `cnt_out` > 0: `cnt_out` ← `cnt_out`-1.
- `phase_done` is 0 in every cycle not covered by the advance case above.
- Phase length is dur[k]+1 ticks, since the zero state lasts one tick. dur[k] = 0 gives a one-tick phase.
- `dur` is sampled only on load cycles. Changing it mid-phase does not affect the running count.
- `init` with multiple bits set loads the lowest set index. `init` = 0 means no load.
- The counter never wraps below 0; advance is the only exit from 0.

## Timing
- All outputs except `last` are registered. `last` follows `cnt_out` in the same cycle.
- `init` to `phase`/`cnt_out`: 1 cycle.
- Tick at `cnt_out` = 0 to new `phase` and `phase_done` high: 1 cycle. `phase_done` deasserts the next cycle.
- `rst` asserted mid-phase returns to reset values on the next edge and discards any pending extension.
- `hold` and `en` in the same cycle: the tick is lost, not deferred.

## Configuration
- `PHASE_TIMER_EXTEND_EN` defined: `ext_req` is granted when `hold` = 0, `init` = 0, `cnt_out` ≠ 0 and `ext_used` = 0.
  - Grant sets `cnt_out` ← min(`cnt_out` + pEXT_TIME, 2^pCNT_WIDTH-1) and `ext_used` ← 1.
  - A coincident `en` decrement is skipped in the grant cycle.
  - Only one grant per phase; later requests are ignored until the next load.
- Macro absent: no extension logic is built, `ext_req` is unused and `ext_used` is tied to 0.

## Test plan
- Reset, dur = {18,3,15} (phase2,1,0), `en` every cycle → first tick: `phase` = 0, `cnt_out` = 15, `phase_done` pulse. After 16 more ticks: `phase` = 1, `cnt_out` = 3.
- Run through phase 2 (`cnt_out` 18→0) → next tick wraps to `phase` = 0, `cnt_out` = 15, `phase_done` high for exactly 1 cycle.
- `init` = 3'b110 mid-count → `phase` = 1, `cnt_out` = 3, no `phase_done`. A `hold` with `en` high for 4 cycles leaves `cnt_out` at 3.
- dur[1] = 0 → phase 1 lasts one tick, with `last` = 1 for that tick. `rst` asserted while `cnt_out` = 7 → next cycle `phase` = 2, `cnt_out` = 0, `last` = 1.
- With the macro, `pCNT_WIDTH` = 5, `cnt_out` = 10 and `ext_req` + `en` in the same cycle → `cnt_out` = 15, `ext_used` = 1. A second `ext_req` has no effect. At `cnt_out` = 29, an extension in a fresh phase saturates at 31.
- Without the macro, `ext_req` held high for a whole phase → identical counts to the first scenario, with `ext_used` = 0 throughout.
